// File: rtl/sm_stack_pkg.sv
// Shared constants and stack-operation decode for the sm_stack LIFO.
package sm_stack_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPL
  } stack_op_e;

  // Push+pop on an empty stack degenerates to a plain push.
  function automatic stack_op_e decode_op(input logic push, input logic pop,
                                          input logic empty, input logic full);
    stack_op_e op;
    op = OP_NONE;
    if (push && pop) op = empty ? OP_PUSH : OP_REPL;
    else if (push)   op = full  ? OP_NONE : OP_PUSH;
    else if (pop)    op = empty ? OP_NONE : OP_POP;
    return op;
  endfunction

endpackage

// File: rtl/sm_stack_ptr.sv
// AW-bit up/down pointer register with async active-high reset to RESET_VAL.
module sm_stack_ptr #(
  parameter int            AW        = 5,
  parameter logic [AW-1:0] RESET_VAL = '1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [AW-1:0] q
);

  logic [AW-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (inc && !dec)      q_d = q_q + AW'(1);
    else if (dec && !inc) q_d = q_q - AW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= RESET_VAL;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/sm_stack.sv
// Parametrised descending LIFO stack with full/empty status and replace-top.
// Optional sticky overflow/underflow flags enabled by `define SM_STACK_ERR_EN.
module sm_stack
  import sm_stack_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [AW-1:0]    sp,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             err_ovf,
  output logic             err_unf,
  input  logic             clr_err
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      count_q, count_d;
  logic [AW-1:0]    sp_q, top_idx;
  stack_op_e        op;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));

  always_comb begin
    op      = decode_op(push, pop, empty, full);
    count_d = count_q;
    case (op)
      OP_PUSH: count_d = count_q + (AW+1)'(1);
      OP_POP:  count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  sm_stack_ptr #(
    .AW        (AW),
    .RESET_VAL ({AW{1'b1}})
  ) u_sp (
    .clk (clk),
    .rst (rst),
    .inc (op == OP_POP),
    .dec (op == OP_PUSH),
    .q   (sp_q)
  );

  assign top_idx = sp_q + AW'(1);

  // Storage is not reset; writes are suppressed while rst is held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (op == OP_PUSH)      mem[sp_q]    <= din;
      else if (op == OP_REPL) mem[top_idx] <= din;
    end
  end

  assign top   = empty ? '0 : mem[top_idx];
  assign sp    = sp_q;
  assign count = count_q;

`ifdef SM_STACK_ERR_EN
  logic err_ovf_q, err_ovf_d, err_unf_q, err_unf_d;

  always_comb begin
    err_ovf_d = clr_err ? 1'b0 : err_ovf_q;
    err_unf_d = clr_err ? 1'b0 : err_unf_q;
    if (push && !pop && full) err_ovf_d = 1'b1;
    if (pop && empty)         err_unf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign err_ovf = 1'b0;
  assign err_unf = 1'b0;
`endif

endmodule

// File: tb/tb_sm_stack.sv
// Self-checking bench for sm_stack (DEPTH=4, WIDTH=32) against a queue model.
module tb_sm_stack;
  import sm_stack_pkg::*;

  localparam int W = 32;
  localparam int D = 4;
  localparam int A = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         push = 1'b0, pop = 1'b0, clr_err = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] top;
  logic [A-1:0] sp;
  logic [A:0]   count;
  logic         empty, full, err_ovf, err_unf;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  sm_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
    .top(top), .sp(sp), .count(count), .empty(empty), .full(full),
    .err_ovf(err_ovf), .err_unf(err_unf), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Reference model: queue back is the top of stack.
  logic [W-1:0] stk[$];
  bit m_ovf = 0, m_unf = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stk.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      stack_op_e k;
      bit set_o, set_u;
      set_o = 0; set_u = 0;
      k = OP_NONE;
      if (push && pop) begin
        if (stk.size() == 0) begin k = OP_PUSH; set_u = 1; end
        else k = OP_REPL;
      end else if (push) begin
        if (stk.size() < D) k = OP_PUSH; else set_o = 1;
      end else if (pop) begin
        if (stk.size() > 0) k = OP_POP; else set_u = 1;
      end
      case (k)
        OP_PUSH: stk.push_back(din);
        OP_POP:  void'(stk.pop_back());
        OP_REPL: stk[stk.size()-1] = din;
        default: ;
      endcase
      if (clr_err) begin m_ovf = 0; m_unf = 0; end
      if (set_o) m_ovf = 1;
      if (set_u) m_unf = 1;
    end
  end

  function automatic logic [W-1:0] exp_top();
    return (stk.size() == 0) ? '0 : stk[stk.size()-1];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      logic [A-1:0] e_sp;
      int sz;
      sz = stk.size();
      e_sp = A'(D - 1 - sz);
      chk("top", 64'(top), 64'(exp_top()));
      chk("sp", 64'(sp), 64'(e_sp));
      chk("count", 64'(count), 64'(sz));
      chk("empty", 64'(empty), 64'(sz == 0));
      chk("full", 64'(full), 64'(sz == D));
`ifdef SM_STACK_ERR_EN
      chk("err_ovf", 64'(err_ovf), 64'(m_ovf));
      chk("err_unf", 64'(err_unf), 64'(m_unf));
`else
      chk("err_ovf", 64'(err_ovf), 64'(0));
      chk("err_unf", 64'(err_unf), 64'(0));
`endif
    end
  end

  task automatic cyc(input logic p, input logic q, input logic [W-1:0] d, input logic c);
    @(negedge clk);
    push = p; pop = q; din = d; clr_err = c;
  endtask

  task automatic idle();
    cyc(0, 0, '0, 0);
    #1;
  endtask

  task automatic chk_err(input string name, input logic o, input logic u);
`ifdef SM_STACK_ERR_EN
    chk({name, "_ovf"}, 64'(err_ovf), 64'(o));
    chk({name, "_unf"}, 64'(err_unf), 64'(u));
`else
    chk({name, "_ovf"}, 64'(err_ovf), 64'(0));
    chk({name, "_unf"}, 64'(err_unf), 64'(0));
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_sp", 64'(sp), 64'(3));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_top", 64'(top), 64'(0));
    chk_err("rst", 0, 0);
    rst = 0;
    chk_en = 1;
    idle();

    cyc(1, 0, 32'hA, 0); cyc(1, 0, 32'hB, 0); cyc(1, 0, 32'hC, 0); cyc(1, 0, 32'hD, 0);
    idle();
    chk("fill_count", 64'(count), 64'(4));
    chk("fill_full", 64'(full), 64'(1));
    chk("fill_sp", 64'(sp), 64'(3));
    chk("fill_top", 64'(top), 64'(32'hD));
    cyc(1, 0, 32'hE, 0);
    idle();
    chk("ovf_top", 64'(top), 64'(32'hD));
    chk_err("ovf", 1, 0);

    cyc(0, 1, '0, 0); idle(); chk("pop1_top", 64'(top), 64'(32'hC));
    cyc(0, 1, '0, 0); idle(); chk("pop2_top", 64'(top), 64'(32'hB));
    cyc(0, 1, '0, 0); idle(); chk("pop3_top", 64'(top), 64'(32'hA));
    cyc(0, 1, '0, 0); idle(); chk("pop4_top", 64'(top), 64'(0));
    chk("pop4_empty", 64'(empty), 64'(1));
    cyc(0, 1, '0, 0); idle();
    chk("unf_count", 64'(count), 64'(0));
    chk_err("unf", 1, 1);

    cyc(1, 0, 32'h11, 0); cyc(1, 1, 32'h22, 0); idle();
    chk("repl_count", 64'(count), 64'(1));
    chk("repl_top", 64'(top), 64'(32'h22));
    cyc(1, 0, 32'h33, 0); cyc(1, 0, 32'h44, 0); cyc(1, 0, 32'h45, 0);
    cyc(1, 1, 32'h55, 0); idle();
    chk("repl_full", 64'(full), 64'(1));
    chk("repl_full_top", 64'(top), 64'(32'h55));
    repeat (4) cyc(0, 1, '0, 0);
    cyc(1, 1, 32'h33, 0); idle();
    chk("pp_empty_count", 64'(count), 64'(1));
    chk("pp_empty_top", 64'(top), 64'(32'h33));
    cyc(0, 0, '0, 1); idle();
    chk_err("clr", 0, 0);

    cyc(1, 0, 32'h1, 0); cyc(1, 0, 32'h2, 0); idle();
    chk("pre_rst_count", 64'(count), 64'(3));
    @(posedge clk); #2;
    rst = 1;
    #1;
    chk("arst_sp", 64'(sp), 64'(3));
    chk("arst_count", 64'(count), 64'(0));
    chk("arst_empty", 64'(empty), 64'(1));
    chk("arst_top", 64'(top), 64'(0));
    @(negedge clk); rst = 0;
    cyc(0, 1, '0, 0); idle();
    chk("post_rst_pop", 64'(count), 64'(0));
    chk_err("post_rst", 0, 1);

    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = ((i / 200) % 2 == 0) ? 70 : 30;
      cyc($urandom_range(99) < bias, $urandom_range(99) < (100 - bias),
          $urandom, $urandom_range(19) == 0);
    end
    idle();
    @(negedge clk);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
